pc_target_table: RTL and testbench
==================================

Name: pc_target_table

Overview:
- Writable, registered successor to the combinational branch-target lookup.
- Holds 2**B entries of D bits. Each entry has a valid bit and an absolute/PC-relative mode bit.
- Resolves a branch index plus the current PC into a next-PC target, one cycle after the request.
- Sits between the decoder (which supplies the index and PC) and the fetch PC register. Includes a bulk-clear sequencer for program reload.

Parameters:
- D, 12, PC / target width in bits.
- B, 5, index width; table depth = 2**B.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- clear, input, 1, single-cycle pulse that starts a bulk invalidate.
- busy, output, 1, high while the clear sequencer is running.
- wr_en, input, 1, entry write strobe.
- wr_addr, input, B, entry index to write.
- wr_data, input, D, absolute target, or two's-complement offset when wr_rel=1.
- wr_rel, input, 1, marks the entry as PC-relative.
- rd_valid, input, 1, lookup request.
- rd_addr, input, B, lookup index.
- rd_pc, input, D, PC of the branch instruction.
- target_valid, output, 1, lookup result valid.
- target, output, D, resolved next PC.
- target_hit, output, 1, indexed entry was valid.

Behaviour:
- Reset: asynchronous on reset_n low.
  - All valid bits 0; FSM = IDLE.
  - busy=0, target_valid=0, target=0, target_hit=0.
  - Data and mode storage are not reset.
- Lookup latency is exactly 1 cycle. rd_valid at edge N gives target_valid=1 during cycle N+1, then it drops unless rd_valid is held. Requests may arrive back-to-back, one per cycle. There is no backpressure.
- Target computation, using the entry state as of edge N:
  - Hit, absolute: target = entry data.
  - Hit, relative: target = (rd_pc + entry data) mod 2**D. The entry is a D-bit two's-complement offset; the carry is discarded. Example: 0x004 + 0xFFF = 0x003.
  - Miss (valid=0): target = (rd_pc + 1) mod 2**D, target_hit=0. 0xFFF wraps to 0x000.
- Write: wr_en at an edge stores {valid=1, rel=wr_rel, data=wr_data} at wr_addr. Visible to lookups from the next edge.
- Same-cycle write and read to the same index: the read returns the pre-write contents (see Optional Feature).
- FSM states:
  - IDLE: clear=1 → CLEAR, counter=0.
  - CLEAR: each cycle zeroes entry[counter] (valid, rel, data); counter increments. After entry 2**B-1 is cleared → IDLE. Takes exactly 2**B cycles.
  - busy=1 exactly while in CLEAR.
- During CLEAR:
  - wr_en is ignored (dropped, not queued).
  - clear is ignored.
  - Lookups are still accepted and always return a miss.
- Reset mid-CLEAR: all valid bits are 0 immediately, FSM returns to IDLE, remaining entries are not walked.
- clear and wr_en together in IDLE: clear wins; the write is dropped.

Optional Feature:
- Macro: PC_TARGET_TABLE_BYPASS_EN.
- Defined: a same-edge write to rd_addr is forwarded, so the lookup uses {1, wr_rel, wr_data}. Not forwarded while busy.
- Undefined: the lookup sees the old entry, as specified above.

Decomposition:
- Shared package pc_table_pkg:
  - typedef pc_entry_t, a struct {valid, rel, data[D-1:0]};
  - enum clr_state_t {IDLE, CLEAR};
  - constants DEF_D=12, DEF_B=5.
- Sub-module pc_target_adder: combinational D-bit modulo adder producing both pc+offset and pc+1. Instantiated once.

Test Plan (D=12, B=5):
- Reset then lookup idx 3 with pc=0x010 → target_valid next cycle, hit=0, target=0x011. With pc=0xFFF → target=0x000.
- Write idx 5 abs 0x123, then next cycle read idx 5 → hit=1, target=0x123, exactly 1 cycle later.
- Write idx 7 rel 0xFFB (−5), read with pc=0x004 → 0xFFF. Write rel 0x014 (+20), read with pc=0x004 → 0x018.
- Same-cycle write idx 9 = 0x055 and read idx 9 after an earlier write of 0x011:
  - macro undefined → 0x011;
  - macro defined → 0x055.
- Fill all 32 entries, pulse clear:
  - busy high exactly 32 cycles;
  - a write during busy is dropped;
  - all post-clear reads miss.
- Pulse clear, assert reset_n=0 on cycle 10 → busy=0 and target_valid=0 immediately. After release, all reads miss and a new write works.

Source files
------------

// File: rtl/pc_table_pkg.sv
// Shared types and default sizes for the PC target table.
package pc_table_pkg;

  localparam int DEF_D = 12;
  localparam int DEF_B = 5;

  // Entry layout at the default target width.
  typedef struct packed {
    logic             valid;
    logic             rel;
    logic [DEF_D-1:0] data;
  } pc_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/pc_target_adder.sv
// Modulo-2**D adder producing pc+offset (signed offset) and pc+1 in parallel.
module pc_target_adder
  import pc_table_pkg::*;
#(
  parameter int D = DEF_D
) (
  input  logic              [D-1:0] pc,
  input  logic signed       [D-1:0] offset,
  output logic              [D-1:0] sum,
  output logic              [D-1:0] inc
);

  // Two's-complement add; the carry out is dropped so results wrap mod 2**D.
  assign sum = pc + $unsigned(offset);
  assign inc = pc + D'(1);

endmodule

// File: rtl/pc_target_table.sv
// Registered branch-target table with bulk-clear sequencer.
// Optional macro PC_TARGET_TABLE_BYPASS_EN forwards a same-edge write to the lookup.
module pc_target_table
  import pc_table_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int B = DEF_B
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  output logic         busy,
  input  logic         wr_en,
  input  logic [B-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         wr_rel,
  input  logic         rd_valid,
  input  logic [B-1:0] rd_addr,
  input  logic [D-1:0] rd_pc,
  output logic         target_valid,
  output logic [D-1:0] target,
  output logic         target_hit
);

  localparam int          DEPTH = 2**B;
  localparam logic [B-1:0] LAST = B'(DEPTH - 1);

  clr_state_t       state_q, state_d;
  logic [B-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rel_q;
  logic [D-1:0]     data_q [DEPTH];

  logic             wr_go;
  logic             ent_valid_p0, ent_rel_p0, hit_p0;
  logic [D-1:0]     ent_data_p0, sum_p0, inc_p0, tgt_p0;
  logic             vld_p1, hit_p1;
  logic [D-1:0]     tgt_p1;

  assign busy  = (state_q == CLEAR);
  // A clear request in IDLE takes priority over a coincident write.
  assign wr_go = (state_q == IDLE) && wr_en && !clear;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + B'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (busy)       valid_q[cnt_q]   <= 1'b0;
      else if (wr_go) valid_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      rel_q[cnt_q]  <= 1'b0;
      data_q[cnt_q] <= '0;
    end else if (wr_go) begin
      rel_q[wr_addr]  <= wr_rel;
      data_q[wr_addr] <= wr_data;
    end
  end

  // ---- stage p0: entry read and target resolve ----
  always_comb begin
    ent_valid_p0 = valid_q[rd_addr] && !busy;
    ent_rel_p0   = rel_q[rd_addr];
    ent_data_p0  = data_q[rd_addr];
`ifdef PC_TARGET_TABLE_BYPASS_EN
    if (wr_go && (wr_addr == rd_addr)) begin
      ent_valid_p0 = 1'b1;
      ent_rel_p0   = wr_rel;
      ent_data_p0  = wr_data;
    end
`endif
    hit_p0 = ent_valid_p0;
    tgt_p0 = inc_p0;
    if (ent_valid_p0) tgt_p0 = ent_rel_p0 ? sum_p0 : ent_data_p0;
  end

  pc_target_adder #(.D(D)) u_adder (
    .pc     (rd_pc),
    .offset ($signed(ent_data_p0)),
    .sum    (sum_p0),
    .inc    (inc_p0)
  );

  // ---- stage p1: registered result ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      hit_p1 <= 1'b0;
      tgt_p1 <= '0;
    end else begin
      vld_p1 <= rd_valid;
      if (rd_valid) begin
        hit_p1 <= hit_p0;
        tgt_p1 <= tgt_p0;
      end
    end
  end

  assign target_valid = vld_p1;
  assign target_hit   = hit_p1;
  assign target       = tgt_p1;

endmodule

// File: tb/tb_pc_target_table.sv
// Scoreboard bench for pc_target_table (D=12, B=5); honours PC_TARGET_TABLE_BYPASS_EN.
module tb_pc_target_table;
  import pc_table_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_rel;
  logic        rd_valid;
  logic [4:0]  rd_addr;
  logic [11:0] rd_pc;
  logic        target_valid;
  logic [11:0] target;
  logic        target_hit;

  pc_target_table #(.D(12), .B(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .busy         (busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_rel       (wr_rel),
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .rd_pc        (rd_pc),
    .target_valid (target_valid),
    .target       (target),
    .target_hit   (target_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        hit;
    logic [11:0] tgt;
  } exp_t;

  exp_t      sb[$];
  pc_entry_t m_tab [32];
  logic      m_busy;
  int        m_cnt;
  int        cyc = 0;
  int        busy_cycles = 0;
  int        n_checks = 0;
  int        n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) busy_cycles++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("target_valid", target_valid, 1);
        check("target_hit", target_hit, sb[0].hit);
        check("target", target, sb[0].tgt);
        void'(sb.pop_front());
      end else begin
        check("target_valid_idle", target_valid, 0);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_tab[i] = '0;
    m_busy = 1'b0;
    m_cnt  = 0;
    sb.delete();
  endtask

  task automatic step(input logic we, input logic [4:0] wa, input logic [11:0] wd,
                      input logic wrl, input logic rv, input logic [4:0] ra,
                      input logic [11:0] pc, input logic clr);
    pc_entry_t e;
    exp_t      x;
    @(posedge clk); #1;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_rel = wrl;
    rd_valid = rv; rd_addr = ra; rd_pc = pc; clear = clr;
    if (rv) begin
      if (m_busy) e = '0;
      else        e = m_tab[ra];
`ifdef PC_TARGET_TABLE_BYPASS_EN
      if (we && !m_busy && !clr && wa == ra) e = '{1'b1, wrl, wd};
`endif
      x.due = cyc + 1;
      x.hit = e.valid;
      if (!e.valid)   x.tgt = pc + 12'd1;
      else if (e.rel) x.tgt = pc + e.data;
      else            x.tgt = e.data;
      sb.push_back(x);
    end
    if (m_busy) begin
      m_tab[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == 32) m_busy = 1'b0;
    end else if (clr) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else if (we) begin
      m_tab[wa] = '{1'b1, wrl, wd};
    end
  endtask

  task automatic rd(input logic [4:0] ra, input logic [11:0] pc);
    step(1'b0, 5'd0, 12'd0, 1'b0, 1'b1, ra, pc, 1'b0);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [11:0] wd, input logic wrl);
    step(1'b1, wa, wd, wrl, 1'b0, 5'd0, 12'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 12'd0, 1'b0, 1'b0, 5'd0, 12'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_rel = 1'b0;
    rd_valid = 1'b0; rd_addr = '0; rd_pc = '0;
    model_reset();
    #12;
    check("reset_busy", busy, 0);
    check("reset_target_valid", target_valid, 0);
    check("reset_target", target, 0);
    check("reset_target_hit", target_hit, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Misses, including PC wrap.
    rd(5'd3, 12'h010);
    rd(5'd3, 12'hFFF);
    idle();

    // Absolute and relative entries.
    wr(5'd5, 12'h123, 1'b0);
    rd(5'd5, 12'h000);
    wr(5'd7, 12'hFFB, 1'b1);
    rd(5'd7, 12'h004);
    wr(5'd7, 12'h014, 1'b1);
    rd(5'd7, 12'h004);
    idle();

    // Same-edge write and read of one index.
    wr(5'd9, 12'h011, 1'b0);
    step(1'b1, 5'd9, 12'h055, 1'b0, 1'b1, 5'd9, 12'h100, 1'b0);
    rd(5'd9, 12'h100);
    idle();

    // Fill every entry, read back, then bulk clear.
    for (int i = 0; i < 32; i++) wr(5'(i), 12'(12'h100 + i * 3), 1'(i % 2));
    for (int i = 0; i < 32; i++) rd(5'(i), 12'h200);
    idle();
    busy_cycles = 0;
    step(1'b1, 5'd2, 12'hABC, 1'b0, 1'b1, 5'd2, 12'h300, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (k == 5) step(1'b1, 5'd2, 12'h777, 1'b0, 1'b1, 5'd6, 12'h040, 1'b0);
      else        rd(5'(k % 32), 12'(12'h400 + k));
    end
    check("busy_cycles", busy_cycles, 32);
    for (int i = 0; i < 32; i++) rd(5'(i), 12'(i * 7));
    idle();

    // Reset in the middle of a clear.
    wr(5'd4, 12'h044, 1'b0);
    step(1'b0, 5'd0, 12'd0, 1'b0, 1'b0, 5'd0, 12'd0, 1'b1);
    for (int k = 0; k < 9; k++) rd(5'd4, 12'h050);
    @(posedge clk); #3;
    check("pre_reset_busy", busy, 1);
    check("pre_reset_target_valid", target_valid, 1);
    reset_n = 1'b0;
    clear = 1'b0; wr_en = 1'b0; rd_valid = 1'b0;
    model_reset();
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_target_valid", target_valid, 0);
    check("async_reset_target", target, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 32; i++) rd(5'(i), 12'h0F0);
    wr(5'd4, 12'h0AA, 1'b0);
    rd(5'd4, 12'h000);
    idle();
    idle();
    idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
